// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display: refresh
// prescaler, digit scan, per-digit enable/blink gating and a frame-synchronous shadow.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  blink_mask,
    input  logic        upd_req,
    input  logic [31:0] upd_data,
    output logic        upd_ack,
    output logic [2:0]  digit_sel,
    output logic [7:0]  an_out,
    output logic [3:0]  digit_bcd,
    output logic        frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc, presc_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_phase, blink_phase_nxt;
    logic [31:0]   shadow, shadow_nxt;
    logic [2:0]    sel_nxt;
    logic [7:0]    an_nxt;
    logic [3:0]    bcd_nxt;
    logic          tick, frame_wrap, load;

    always_comb begin
        tick            = en && (presc == PRESC_MAX);
        frame_wrap      = tick && (digit_sel == 3'd7);
        presc_nxt       = presc;
        sel_nxt         = digit_sel;
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;

        if (en) begin
            presc_nxt = tick ? '0 : presc + 1'b1;
        end
        if (tick) begin
            sel_nxt = digit_sel + 3'd1;
        end
        if (frame_wrap) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end

        // While scanning, the shadow only changes on the frame boundary so a frame never tears.
        load       = upd_req && !upd_ack && (en ? frame_wrap : 1'b1);
        shadow_nxt = load ? upd_data : shadow;

        // Outputs follow the next-state index so they move on the same edge as digit_sel.
        an_nxt = 8'hFF;
        if (en && digit_en[sel_nxt] && !(blink_mask[sel_nxt] && blink_phase_nxt)) begin
            an_nxt[sel_nxt] = 1'b0;
        end
        bcd_nxt = shadow_nxt[{sel_nxt, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc       <= '0;
            digit_sel   <= 3'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow      <= 32'd0;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
            an_out      <= 8'hFF;
            digit_bcd   <= 4'd0;
        end else begin
            presc       <= presc_nxt;
            digit_sel   <= sel_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            shadow      <= shadow_nxt;
            upd_ack     <= load;
            frame_start <= frame_wrap;
            an_out      <= an_nxt;
            digit_bcd   <= bcd_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-based reference of the scan position plus a queue
// of pending display words that is drained when a load is due.
module tb_seg_scan_ctrl;

    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FRAME = 8 * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  digit_en = 8'hFF;
    logic [7:0]  blink_mask = 8'h00;
    logic        upd_req = 1'b0;
    logic [31:0] upd_data = 32'd0;
    logic        upd_ack;
    logic [2:0]  digit_sel;
    logic [7:0]  an_out;
    logic [3:0]  digit_bcd;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .upd_req    (upd_req),
        .upd_data   (upd_data),
        .upd_ack    (upd_ack),
        .digit_sel  (digit_sel),
        .an_out     (an_out),
        .digit_bcd  (digit_bcd),
        .frame_start(frame_start)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          t = 0;
    int          fs_count = 0;
    logic [31:0] m_shadow = 32'd0;
    logic        m_ack = 1'b0;
    logic [31:0] exp_q[$];
    logic        acked;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    // Inputs only change #1 after an edge, so reading them here gives the values the edge saw.
    task automatic cycle();
        logic       bnd;
        logic       load;
        logic       ph;
        int         d;
        logic [7:0] exp_an;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            t        = 0;
            m_shadow = 32'd0;
            m_ack    = 1'b0;
            exp_q.delete();
            check("rst_an_out", 32'(an_out), 32'hFF);
            check("rst_digit_sel", 32'(digit_sel), 32'd0);
            check("rst_digit_bcd", 32'(digit_bcd), 32'd0);
            check("rst_upd_ack", 32'(upd_ack), 32'd0);
            check("rst_frame_start", 32'(frame_start), 32'd0);
        end else begin
            bnd = 1'b0;
            if (en) begin
                t++;
                bnd = ((t % FRAME) == 0);
            end
            load = upd_req && !m_ack && (en ? bnd : 1'b1);
            if (load) begin
                if (exp_q.size() == 0) check("sb_size", 32'(exp_q.size()), 32'd1);
                else m_shadow = exp_q.pop_front();
            end
            m_ack  = load;
            d      = (t / RD) % 8;
            ph     = (((t / (FRAME * BF)) % 2) == 1);
            exp_an = 8'hFF;
            if (en && digit_en[d] && !(blink_mask[d] && ph)) exp_an[d] = 1'b0;
            check("digit_sel", 32'(digit_sel), 32'(d));
            check("an_out", 32'(an_out), 32'(exp_an));
            check("digit_bcd", 32'(digit_bcd), 32'(m_shadow[4*d +: 4]));
            check("frame_start", 32'(frame_start), 32'(en && bnd));
            check("upd_ack", 32'(upd_ack), 32'(m_ack));
            if (frame_start) fs_count++;
        end
    endtask

    initial begin
        // Reset held for three edges, then two full frames of plain scanning.
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        fs_count = 0;
        repeat (2 * FRAME) cycle();
        check("frame_start_count", 32'(fs_count), 32'd2);

        digit_en   = 8'hF0;
        blink_mask = 8'h01;
        repeat (4 * FRAME) cycle();

        digit_en = 8'hFF;
        repeat (8 * FRAME) cycle();

        // Update requested mid-frame at digit 3.
        for (int i = 0; i < FRAME && ((t / RD) % 8) != 3; i++) cycle();
        check("reach_digit3", 32'((t / RD) % 8), 32'd3);
        upd_data = 32'h12345678;
        upd_req  = 1'b1;
        exp_q.push_back(upd_data);
        acked = 1'b0;
        for (int i = 0; i < FRAME + 2 && !acked; i++) begin
            cycle();
            if (upd_ack) acked = 1'b1;
        end
        upd_req = 1'b0;
        check("ack1_seen", 32'(acked), 32'd1);
        check("ack1_digit_sel", 32'(digit_sel), 32'd0);
        blink_mask = 8'h00;
        repeat (FRAME + 4) cycle();

        // Disable mid-slot at digit 5, update while dark, then resume.
        for (int i = 0; i < FRAME && (t % FRAME) != (5 * RD + 1); i++) cycle();
        check("reach_digit5", 32'(t % FRAME), 32'(5 * RD + 1));
        en = 1'b0;
        repeat (3) cycle();
        upd_data = 32'hCAFEBABE;
        upd_req  = 1'b1;
        exp_q.push_back(upd_data);
        cycle();
        check("ack2_next_cycle", 32'(upd_ack), 32'd1);
        upd_req = 1'b0;
        repeat (3) cycle();
        en = 1'b1;
        repeat (FRAME + 8) cycle();

        // Reset while a request is still pending.
        for (int i = 0; i < FRAME && ((t / RD) % 8) != 2; i++) cycle();
        check("reach_digit2", 32'((t / RD) % 8), 32'd2);
        upd_data = 32'h87654321;
        upd_req  = 1'b1;
        exp_q.push_back(upd_data);
        repeat (2) cycle();
        rst_n   = 1'b0;
        upd_req = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (FRAME + 8) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
